// File: rtl/forward_scoreboard.sv
// Forwarding/hazard scoreboard: tracks EX/MEM/WB destination tags and picks operand bypass sources.
// Optional macro FORWARD_SCOREBOARD_STATS_EN adds saturating stall/load-use event counters.
module forward_scoreboard #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREAD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [NREAD*5-1:0]    id_rs,
  input  logic [NREAD-1:0]      id_rs_used,
  input  logic [4:0]            id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memtoreg,
  input  logic [XLEN-1:0]       ex_result,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic [XLEN-1:0]       mem_load_data,
  input  logic                  mem_load_valid,
  input  logic [XLEN-1:0]       wb_data,
  output logic [NREAD*2-1:0]    fwd_sel,
  output logic [NREAD*XLEN-1:0] fwd_data,
  output logic                  stall,
  output logic                  flush
`ifdef FORWARD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           loaduse_events
`endif
);

  localparam int unsigned RW = 5;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic          regwrite;
    logic          memtoreg;
  } tag_t;

  tag_t          ex_q, mem_q, wb_q;
  tag_t          id_tag, bubble;
  logic          ex_wr, mem_wr, wb_wr;
  logic          mem_wait, load_use;
  logic [RW-1:0] rs;

  always_comb begin
    id_tag = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memtoreg: id_memtoreg};
    bubble = '0;
    ex_wr  = ex_q.valid  && ex_q.regwrite  && (ex_q.rd  != RW'(0));
    mem_wr = mem_q.valid && mem_q.regwrite && (mem_q.rd != RW'(0));
    wb_wr  = wb_q.valid  && wb_q.regwrite  && (wb_q.rd  != RW'(0));
  end

  // Per-port bypass selection, youngest writer first; a matching load in EX blocks older sources.
  always_comb begin
    fwd_sel  = '0;
    fwd_data = '0;
    load_use = 1'b0;
    rs       = '0;
    mem_wait = mem_wr && mem_q.memtoreg && !mem_load_valid;
    for (int k = 0; k < int'(NREAD); k++) begin
      rs = id_rs[5*k +: 5];
      if (id_rs_used[k] && (rs != RW'(0))) begin
        if (ex_wr && (ex_q.rd == rs)) begin
          if (ex_q.memtoreg) begin
            load_use = load_use | id_valid;
          end else begin
            fwd_sel[2*k +: 2]     = 2'd1;
            fwd_data[XLEN*k +: XLEN] = ex_result;
          end
        end else if (mem_wr && (mem_q.rd == rs)) begin
          fwd_sel[2*k +: 2]        = 2'd2;
          fwd_data[XLEN*k +: XLEN] = mem_q.memtoreg ? mem_load_data : mem_alu_result;
        end else if (wb_wr && (wb_q.rd == rs)) begin
          fwd_sel[2*k +: 2]        = 2'd3;
          fwd_data[XLEN*k +: XLEN] = wb_data;
        end
      end
    end
    stall = mem_wait || load_use;
    flush = load_use && !mem_wait;
  end

  // Tag pipeline: hold everything on mem-wait, inject a bubble into EX on load-use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!mem_wait) begin
      ex_q  <= load_use ? bubble : id_tag;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

`ifdef FORWARD_SCOREBOARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles   <= '0;
      loaduse_events <= '0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush && (loaduse_events != 32'hFFFF_FFFF)) begin
        loaduse_events <= loaduse_events + 32'd1;
      end
    end
  end
`endif

endmodule
